// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC encodings: opcodes, instruction field positions and
// immediate-modifier codes used by the operand-fetch stage.
package simplerisc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MUL  = 5'd2,  OP_DIV  = 5'd3,
    OP_MOD  = 5'd4,  OP_CMP  = 5'd5,  OP_AND  = 5'd6,  OP_OR   = 5'd7,
    OP_NOT  = 5'd8,  OP_MOV  = 5'd9,  OP_LSL  = 5'd10, OP_LSR  = 5'd11,
    OP_ASR  = 5'd12, OP_NOP  = 5'd13, OP_LD   = 5'd14, OP_ST   = 5'd15,
    OP_BEQ  = 5'd16, OP_BGT  = 5'd17, OP_B    = 5'd18, OP_CALL = 5'd19,
    OP_RET  = 5'd20
  } opcode_t;

  localparam logic [31:0] NOP_INST = 32'h6800_0000;
  localparam logic [3:0]  REG_RA   = 4'd15;

  localparam int OPC_LSB = 27;
  localparam int I_BIT   = 26;
  localparam int RD_LSB  = 22;
  localparam int RS1_LSB = 18;
  localparam int RS2_LSB = 14;
  localparam int MOD_LSB = 16;
  localparam int OFF_W   = 27;

  localparam logic [1:0] IMM_SEXT = 2'b00;
  localparam logic [1:0] IMM_ZEXT = 2'b01;
  localparam logic [1:0] IMM_HI   = 2'b10;

endpackage

// File: rtl/of_decode.sv
// Combinational field decode: register-port addresses, source-use flags,
// extended immediate and sign-extended branch offset.
module of_decode
  import simplerisc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [3:0]      ra1_o,
  output logic [3:0]      ra2_o,
  output logic            uses_rs1_o,
  output logic            uses_rs2_o,
  output logic [XLEN-1:0] immx_o,
  output logic [XLEN-1:0] off_o
);

  logic [4:0]  opc;
  logic        i_bit;
  logic [1:0]  imod;
  logic [15:0] imm16;
  logic        is_alu;

  assign opc    = inst_i[OPC_LSB +: 5];
  assign i_bit  = inst_i[I_BIT];
  assign imod   = inst_i[MOD_LSB +: 2];
  assign imm16  = inst_i[15:0];
  assign is_alu = (opc <= OP_ASR);

  assign ra1_o = (opc == OP_RET) ? REG_RA : inst_i[RS1_LSB +: 4];
  assign ra2_o = (opc == OP_ST)  ? inst_i[RD_LSB +: 4] : inst_i[RS2_LSB +: 4];

  // mov/not take their source through rs2, so they only hit the rs2 check
  assign uses_rs1_o = !(opc inside {OP_NOP, OP_B, OP_CALL, OP_MOV, OP_NOT});
  assign uses_rs2_o = (is_alu && !i_bit) || (opc == OP_ST);

  always_comb begin
    immx_o = {{(XLEN-16){imm16[15]}}, imm16};
    case (imod)
      IMM_ZEXT: immx_o = {{(XLEN-16){1'b0}}, imm16};
      IMM_HI:   immx_o = {{(XLEN-16){1'b0}}, imm16} << 16;
      default:  immx_o = {{(XLEN-16){imm16[15]}}, imm16};
    endcase
  end

  assign off_o = {{(XLEN-OFF_W){inst_i[OFF_W-1]}}, inst_i[OFF_W-1:0]};

endmodule

// File: rtl/of_unit.sv
// Operand-fetch stage: pairs inst with its PC, reads operands, forms the
// branch target, and owns the load-use interlock and wrong-path squash.
module of_unit
  import simplerisc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FLUSH_SLOTS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic            isBranchTaken,
  output logic            stop,
  output logic [3:0]      rf_ra1,
  output logic [3:0]      rf_ra2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic            ex_valid,
  output logic [31:0]     ex_inst,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_immx,
  output logic [XLEN-1:0] ex_btarget
);

  localparam logic [1:0] SQ_LOAD = 2'(FLUSH_SLOTS);

  logic            uses_rs1, uses_rs2;
  logic [XLEN-1:0] immx, off;

  of_decode #(.XLEN(XLEN)) u_dec (
    .inst_i     (inst),
    .ra1_o      (rf_ra1),
    .ra2_o      (rf_ra2),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2),
    .immx_o     (immx),
    .off_o      (off)
  );

  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [1:0]      sq_q, sq_d;
  logic            ex_valid_q, ex_valid_d;
  logic [31:0]     ex_inst_q, ex_inst_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d, ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d;
  logic [XLEN-1:0] ex_immx_q, ex_immx_d, ex_bt_q, ex_bt_d;
  logic            ld_use;
  logic [3:0]      ex_rd;

  assign ex_rd  = ex_inst_q[RD_LSB +: 4];
  assign ld_use = ex_valid_q && (ex_inst_q[OPC_LSB +: 5] == OP_LD) &&
                  ((uses_rs1 && (ex_rd == rf_ra1)) ||
                   (uses_rs2 && (ex_rd == rf_ra2)));

  // A squash in flight or starting now overrides the interlock
  assign stop = ld_use && !isBranchTaken && (sq_q == 2'd0);

  always_comb begin
    inst_pc_d  = pc;
    sq_d       = sq_q;
    ex_valid_d = 1'b0;
    ex_inst_d  = NOP_INST;
    ex_pc_d    = '0;
    ex_op1_d   = '0;
    ex_op2_d   = '0;
    ex_immx_d  = '0;
    ex_bt_d    = '0;
    if (isBranchTaken) begin
      sq_d = SQ_LOAD;
    end else if (sq_q != 2'd0) begin
      sq_d = sq_q - 2'd1;
    end else if (ld_use) begin
      inst_pc_d = inst_pc_q;
    end else begin
      ex_valid_d = 1'b1;
      ex_inst_d  = inst;
      ex_pc_d    = inst_pc_q;
      ex_op1_d   = rf_rd1;
      ex_op2_d   = rf_rd2;
      ex_immx_d  = immx;
      ex_bt_d    = inst_pc_q + off;
    end
  end

  // Counter starts at 1: memory output is garbage on the first cycle out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_pc_q  <= '0;
      sq_q       <= 2'd1;
      ex_valid_q <= 1'b0;
      ex_inst_q  <= NOP_INST;
      ex_pc_q    <= '0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_immx_q  <= '0;
      ex_bt_q    <= '0;
    end else begin
      inst_pc_q  <= inst_pc_d;
      sq_q       <= sq_d;
      ex_valid_q <= ex_valid_d;
      ex_inst_q  <= ex_inst_d;
      ex_pc_q    <= ex_pc_d;
      ex_op1_q   <= ex_op1_d;
      ex_op2_q   <= ex_op2_d;
      ex_immx_q  <= ex_immx_d;
      ex_bt_q    <= ex_bt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_inst    = ex_inst_q;
  assign ex_pc      = ex_pc_q;
  assign ex_op1     = ex_op1_q;
  assign ex_op2     = ex_op2_q;
  assign ex_immx    = ex_immx_q;
  assign ex_btarget = ex_bt_q;

endmodule
